// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// mem_bus_arbiter
// Round-robin arbiter for a shared external memory bus (PSRAM, parallel
// flash, QSPI). A grant is held until the owner signals DONE, drops its
// request, or exceeds MAX_HOLD cycles. A bus-idle turnaround of TURNAROUND
// cycles follows every grant.
//
// Parameters
//   TURNAROUND  idle cycles between two grants (1..15)
//   MAX_HOLD    maximum cycles a grant is held (0..1023, 0 = unlimited)
//
// Ports
//   GCLK     in   clock, rising edge
//   RESET    in   asynchronous active-low reset
//   REQ      in   [2:0] request: bit0 PSRAM, bit1 flash, bit2 QSPI
//   DONE     in   [2:0] one-cycle release pulse, same bit order as REQ
//   GNT      out  [2:0] one-hot grant, zero when no grant
//   BUS_SEL  out  [1:0] mux select: 0 none, 1 PSRAM, 2 flash, 3 QSPI
//   BUS_OE   out  drive enable for the shared DQ/address pins
//   TIMEOUT  out  one-cycle pulse when a grant was revoked by MAX_HOLD
//   BUSY     out  high whenever the arbiter is not idle
module mem_bus_arbiter #(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned MAX_HOLD   = 255
) (
    input  logic       GCLK,
    input  logic       RESET,
    input  logic [2:0] REQ,
    input  logic [2:0] DONE,
    output logic [2:0] GNT,
    output logic [1:0] BUS_SEL,
    output logic       BUS_OE,
    output logic       TIMEOUT,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [9:0] HOLD_LAST = 10'(MAX_HOLD - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

    state_t     state;
    logic       rst_sync_n;
    logic [9:0] hold_cnt;
    logic [3:0] turn_cnt;
    logic [1:0] last;       // previous owner; equals the current owner during GRANT
    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       normal_release;
    logic       hold_hit;

    // NOTE: assertion reaches the FSM asynchronously through this flop's clear,
    // while deassertion is retimed to GCLK; the FSM leaves reset one edge after
    // release, so the first grant decision happens at the second edge.
    always_ff @(posedge GCLK or negedge RESET) begin
        if (!RESET) begin
            rst_sync_n <= 1'b0;
        end else begin
            rst_sync_n <= 1'b1;
        end
    end

    // Round-robin search starting at the requester after the previous owner.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves one unassigned, which would infer a latch.
        winner = last;
        cand   = 2'd0;
        found  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cand = 2'((int'(last) + i) % 3);
            if (!found && REQ[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Only the owner's bits matter while a grant is active.
    assign normal_release = DONE[last] || !REQ[last];
    assign hold_hit       = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    // NOTE: all state and outputs use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge GCLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= IDLE;
            GNT      <= 3'b000;
            BUS_SEL  <= 2'd0;
            BUS_OE   <= 1'b0;
            TIMEOUT  <= 1'b0;
            BUSY     <= 1'b0;
            hold_cnt <= 10'd0;
            turn_cnt <= 4'd0;
            last     <= 2'd2;
        end else begin
            TIMEOUT <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (REQ != 3'b000) begin
                        state    <= GRANT;
                        last     <= winner;
                        GNT      <= 3'b001 << winner;
                        BUS_SEL  <= winner + 2'd1;
                        BUS_OE   <= 1'b1;
                        BUSY     <= 1'b1;
                        hold_cnt <= 10'd0;
                    end
                end
                GRANT: begin
                    if (normal_release || hold_hit) begin
                        state    <= TURN;
                        GNT      <= 3'b000;
                        BUS_SEL  <= 2'd0;
                        BUS_OE   <= 1'b0;
                        // A simultaneous DONE or request drop wins over the limit.
                        TIMEOUT  <= hold_hit && !normal_release;
                        turn_cnt <= 4'd0;
                    end else if (hold_cnt != 10'h3FF) begin
                        hold_cnt <= hold_cnt + 10'd1;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        turn_cnt <= turn_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_bus_arbiter. Two instances share stimulus:
// instance A uses default parameters, instance B a short hold limit and a
// longer turnaround. A behavioural model (owner / grant age / turnaround
// countdown) predicts every output each cycle; directed sequences pin the
// model with literal expectations.
module tb_mem_bus_arbiter;

    localparam int MH_A = 255;
    localparam int TA_A = 2;
    localparam int MH_B = 4;
    localparam int TA_B = 3;

    logic       GCLK  = 1'b0;
    logic       RESET = 1'b0;
    logic [2:0] REQ   = 3'b000;
    logic [2:0] DONE  = 3'b000;

    logic [2:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       oe_a, oe_b, to_a, to_b, busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 GCLK = ~GCLK;

    mem_bus_arbiter #(.TURNAROUND(TA_A), .MAX_HOLD(MH_A)) dut_a (
        .GCLK(GCLK), .RESET(RESET), .REQ(REQ), .DONE(DONE),
        .GNT(gnt_a), .BUS_SEL(sel_a), .BUS_OE(oe_a), .TIMEOUT(to_a), .BUSY(busy_a)
    );

    mem_bus_arbiter #(.TURNAROUND(TA_B), .MAX_HOLD(MH_B)) dut_b (
        .GCLK(GCLK), .RESET(RESET), .REQ(REQ), .DONE(DONE),
        .GNT(gnt_b), .BUS_SEL(sel_b), .BUS_OE(oe_b), .TIMEOUT(to_b), .BUSY(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mh[2] = '{MH_A, MH_B};
    int ta[2] = '{TA_A, TA_B};
    int m_owner[2];   // -1 = no grant
    int m_age[2];     // cycles the current owner has held the bus, 1 = first
    int m_gap[2];     // turnaround cycles still to come
    int m_last[2];
    int m_armed[2];   // 0 until the first edge after reset release
    bit m_to[2];

    function automatic void model_reset(input int d);
        m_owner[d] = -1;
        m_age[d]   = 0;
        m_gap[d]   = 0;
        m_last[d]  = 2;
        m_armed[d] = 0;
        m_to[d]    = 1'b0;
    endfunction

    function automatic void model_step(input int d);
        bit rel_norm;
        bit rel_time;
        bit found;
        int c;
        m_to[d] = 1'b0;
        if (m_armed[d] == 0) begin
            m_armed[d] = 1;
        end else if (m_owner[d] >= 0) begin
            rel_norm = DONE[m_owner[d]] || !REQ[m_owner[d]];
            rel_time = (mh[d] != 0) && (m_age[d] >= mh[d]);
            if (rel_norm || rel_time) begin
                m_owner[d] = -1;
                m_gap[d]   = ta[d];
                m_to[d]    = !rel_norm;
            end else begin
                m_age[d]++;
            end
        end else if (m_gap[d] > 0) begin
            m_gap[d]--;
        end else if (REQ != 3'b000) begin
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                c = (m_last[d] + k) % 3;
                if (!found && REQ[c]) begin
                    m_owner[d] = c;
                    found = 1'b1;
                end
            end
            m_last[d] = m_owner[d];
            m_age[d]  = 1;
        end
    endfunction

    always @(posedge GCLK or negedge RESET) begin
        if (!RESET) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic compare(input int d, input logic [2:0] g, input logic [1:0] s,
                           input logic oe, input logic t, input logic b);
        logic [2:0] eg;
        logic [1:0] es;
        string      p;
        p  = (d == 0) ? "A" : "B";
        eg = (m_owner[d] >= 0) ? 3'(1 << m_owner[d]) : 3'b000;
        es = (m_owner[d] >= 0) ? 2'(m_owner[d] + 1) : 2'd0;
        check({p, ".gnt"},     32'(g),  32'(eg));
        check({p, ".bus_sel"}, 32'(s),  32'(es));
        check({p, ".bus_oe"},  32'(oe), 32'(m_owner[d] >= 0));
        check({p, ".timeout"}, 32'(t),  32'(m_to[d]));
        check({p, ".busy"},    32'(b),  32'((m_owner[d] >= 0) || (m_gap[d] > 0)));
        check({p, ".onehot"},  32'($countones(g) <= 1), 32'd1);
    endtask

    always @(negedge GCLK) begin
        compare(0, gnt_a, sel_a, oe_a, to_a, busy_a);
        compare(1, gnt_b, sel_b, oe_b, to_b, busy_b);
    end

    // ---------------- grant history of instance A ----------------
    logic [2:0] mon_prev = 3'b000;
    int         mon_run  = 0;
    int         to_cnt   = 0;
    logic [2:0] gq[$];
    int         lq[$];
    int         gapq[$];

    always @(negedge GCLK) begin
        if (gnt_a == mon_prev) begin
            mon_run++;
        end else begin
            if (mon_prev != 3'b000) begin
                gq.push_back(mon_prev);
                lq.push_back(mon_run);
            end else begin
                gapq.push_back(mon_run);
            end
            mon_prev = gnt_a;
            mon_run  = 1;
        end
        if (to_a) to_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge GCLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        REQ   = 3'b000;
        DONE  = 3'b000;
        repeat (3) step();
        gq.delete();
        lq.delete();
        gapq.delete();
        mon_prev = gnt_a;
        mon_run  = 0;
        to_cnt   = 0;
        RESET = 1'b1;
    endtask

    task automatic wait_gnt(input int d, input string tag);
        int n;
        n = 0;
        while (((d == 0) ? gnt_a : gnt_b) == 3'b000 && n < 60) begin
            step();
            n++;
        end
        check({tag, ".grant_seen"}, 32'(((d == 0) ? gnt_a : gnt_b) != 3'b000), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset values
        do_reset();
        RESET = 1'b0;
        step();
        check("rst.gnt",     32'(gnt_a),   32'h0);
        check("rst.bus_sel", 32'(sel_a),   32'h0);
        check("rst.bus_oe",  32'(oe_a),    32'h0);
        check("rst.timeout", 32'(to_a),    32'h0);
        check("rst.busy",    32'(busy_a),  32'h0);

        // All three requesting, no DONE: rotation with hold-limit timeouts
        do_reset();
        REQ = 3'b111;
        step();
        check("sync.edge1_no_grant", 32'(gnt_a), 32'h0);
        step();
        check("sync.edge2_grant", 32'(gnt_a), 32'b001);
        n = 0;
        while (!(gq.size() >= 3 && gnt_a != 3'b000) && n < 2000) begin
            step();
            n++;
        end
        check("rot.grants_done", 32'(gq.size()), 32'd3);
        check("rot.fourth", 32'(gnt_a), 32'b001);
        if (gq.size() >= 3 && gapq.size() >= 4) begin
            check("rot.g0", 32'(gq[0]), 32'b001);
            check("rot.g1", 32'(gq[1]), 32'b010);
            check("rot.g2", 32'(gq[2]), 32'b100);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rot.len%0d", i), 32'(lq[i]), 32'd255);
                // TURNAROUND idle cycles plus the IDLE cycle that samples REQ
                check($sformatf("rot.gap%0d", i), 32'(gapq[i + 1]), 32'd3);
            end
        end
        check("rot.timeouts", 32'(to_cnt), 32'd3);

        // Flash alone, DONE on the 5th grant cycle
        do_reset();
        REQ = 3'b010;
        wait_gnt(0, "done5");
        repeat (4) step();
        check("done5.gnt", 32'(gnt_a), 32'b010);
        check("done5.sel", 32'(sel_a), 32'd2);
        check("done5.oe",  32'(oe_a),  32'd1);
        DONE = 3'b010;
        step();
        DONE = 3'b000;
        REQ  = 3'b000;
        check("done5.turn1_gnt",  32'(gnt_a),  32'h0);
        check("done5.turn1_oe",   32'(oe_a),   32'h0);
        check("done5.turn1_to",   32'(to_a),   32'h0);
        check("done5.turn1_busy", 32'(busy_a), 32'h1);
        step();
        check("done5.turn2_busy", 32'(busy_a), 32'h1);
        step();
        check("done5.idle_busy",  32'(busy_a), 32'h0);
        check("done5.len", 32'((lq.size() > 0) ? lq[lq.size() - 1] : 0), 32'd5);

        // PSRAM owner drops its request while QSPI waits
        do_reset();
        REQ = 3'b101;
        wait_gnt(0, "drop");
        check("drop.first", 32'(gnt_a), 32'b001);
        repeat (2) step();
        REQ = 3'b100;
        step();
        check("drop.turn1", 32'(gnt_a), 32'h0);
        step();
        check("drop.turn2", 32'(gnt_a), 32'h0);
        step();
        check("drop.idle", 32'(gnt_a), 32'h0);
        step();
        check("drop.qspi", 32'(gnt_a), 32'b100);

        // Hold limit 4: DONE on the 4th cycle is a normal release
        do_reset();
        REQ = 3'b001;
        wait_gnt(1, "hold4");
        check("hold4.gnt", 32'(gnt_b), 32'b001);
        repeat (3) step();
        DONE = 3'b001;
        step();
        DONE = 3'b000;
        check("hold4.done_gnt", 32'(gnt_b), 32'h0);
        check("hold4.done_to",  32'(to_b),  32'h0);
        // Same owner again without DONE: revoked by the limit
        wait_gnt(1, "hold4b");
        repeat (3) step();
        check("hold4.cycle4", 32'(gnt_b), 32'b001);
        step();
        check("hold4.to_gnt",   32'(gnt_b), 32'h0);
        check("hold4.to_pulse", 32'(to_b),  32'h1);
        step();
        check("hold4.to_once",  32'(to_b),  32'h0);

        // Asynchronous reset in the middle of a flash grant
        do_reset();
        REQ = 3'b010;
        wait_gnt(0, "arst");
        step();
        #2;
        RESET = 1'b0;
        #1;
        check("arst.gnt",  32'(gnt_a), 32'h0);
        check("arst.sel",  32'(sel_a), 32'h0);
        check("arst.oe",   32'(oe_a),  32'h0);
        REQ = 3'b110;
        step();
        RESET = 1'b1;
        step();
        check("arst.edge1", 32'(gnt_a), 32'h0);
        step();
        check("arst.flash_first", 32'(gnt_a), 32'b010);

        // Random traffic, alternating busy and quiet phases
        do_reset();
        for (int c = 0; c < 20000; c++) begin
            step();
            if ((c / 2000) % 2 == 0) begin
                if ($urandom_range(0, 7) == 0) REQ = 3'($urandom);
                DONE = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            end else begin
                if ($urandom_range(0, 511) == 0) REQ = 3'($urandom);
                DONE = 3'b000;
            end
            if ($urandom_range(0, 3999) == 0) begin
                RESET = 1'b0;
                step();
                RESET = 1'b1;
            end
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
